// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash read arbiter.
// Holds the FSM state encoding, the address and length field widths and
// the default WAIT timeout used by flash_read_arbiter and flash_arb_rr.
package flash_arb_pkg;

    localparam int ADDR_W          = 24;
    localparam int LEN_W           = 8;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker.
// Ports:
//   req_i  [1:0] request levels from requester 0 / 1
//   last_i       requester served most recently (0 or 1)
//   win_o  [1:0] one-hot winner, zero when nothing is requested
module flash_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    // Under contention the requester that was not served last wins.
    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = last_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates burst reads from two requesters onto a byte-wide flash reader
// and streams the returned bytes to a ready/valid consumer.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_i/req_addr_i/req_len_i     per-requester burst request, start address, length-1
//   gnt_o                          one-cycle grant pulse when a burst is latched
//   busy_o                         high whenever a burst is in progress
//   dout_valid_o/_data_o/_id_o/_last_o, dout_ready_i   byte stream to consumer
//   spi_read_o/spi_addr_o          byte-read command to the flash reader
//   spi_ready_i/spi_data_i         flash reader completion pulse and byte
//   err_o                          one-cycle pulse when a burst is dropped on timeout
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*LEN_W-1:0]  req_len_i,
    output logic [1:0]          gnt_o,
    output logic                busy_o,
    output logic                dout_valid_o,
    output logic [7:0]          dout_data_o,
    output logic                dout_id_o,
    output logic                dout_last_o,
    input  logic                dout_ready_i,
    output logic                spi_read_o,
    output logic [ADDR_W-1:0]   spi_addr_o,
    input  logic                spi_ready_i,
    input  logic [7:0]          spi_data_i,
    output logic                err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                id_q, id_d;
    logic                last_q, last_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                dout_valid_q, dout_valid_d;
    logic [7:0]          dout_data_q, dout_data_d;
    logic                dout_last_q, dout_last_d;
    logic                spi_read_q, spi_read_d;
    logic                err_q, err_d;
    logic [1:0]          win_s;

    flash_arb_rr u_rr (
        .req_i  (req_i),
        .last_i (last_q),
        .win_o  (win_s)
    );

    // Next-state and next-output logic; outputs are registered so each
    // one is computed for the cycle in which the FSM enters its state.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_d       = last_q;
        gnt_d        = 2'b00;
        spi_read_d   = 1'b0;
        err_d        = 1'b0;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_last_d  = dout_last_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    state_d    = ST_ISSUE;
                    gnt_d      = win_s;
                    id_d       = win_s[1];
                    addr_d     = win_s[1] ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
                    rem_d      = win_s[1] ? req_len_i[2*LEN_W-1:LEN_W] : req_len_i[LEN_W-1:0];
                    spi_read_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                // A completion in the final counted cycle still wins over the timeout.
                if (spi_ready_i) begin
                    state_d      = ST_DELIVER;
                    dout_valid_d = 1'b1;
                    dout_data_d  = spi_data_i;
                    dout_last_d  = (rem_q == {LEN_W{1'b0}});
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    last_d  = id_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DELIVER: begin
                if (dout_ready_i) begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    if (rem_q == {LEN_W{1'b0}}) begin
                        state_d = ST_IDLE;
                        last_d  = id_q;
                    end else begin
                        state_d    = ST_ISSUE;
                        addr_d     = addr_q + ADDR_W'(1);
                        rem_d      = rem_q - LEN_W'(1);
                        spi_read_d = 1'b1;
                    end
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            rem_q        <= {LEN_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            gnt_q        <= 2'b00;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= 8'h00;
            dout_last_q  <= 1'b0;
            spi_read_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_last_q  <= dout_last_d;
            spi_read_q   <= spi_read_d;
            err_q        <= err_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign busy_o       = busy_q;
    assign dout_valid_o = dout_valid_q;
    assign dout_data_o  = dout_data_q;
    assign dout_id_o    = id_q;
    assign dout_last_o  = dout_last_q;
    assign spi_read_o   = spi_read_q;
    assign spi_addr_o   = addr_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: table-driven burst vectors
// plus hand-written stall, timeout and mid-burst reset sequences.
module tb_flash_read_arbiter;
    import flash_arb_pkg::*;

    localparam int LAT = 48;
    localparam int TO  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i;
    logic [47:0] req_addr_i;
    logic [15:0] req_len_i;
    logic [1:0]  gnt_o;
    logic        busy_o;
    logic        dout_valid_o;
    logic [7:0]  dout_data_o;
    logic        dout_id_o;
    logic        dout_last_o;
    logic        dout_ready_i;
    logic        spi_read_o;
    logic [23:0] spi_addr_o;
    logic        spi_ready_i;
    logic [7:0]  spi_data_i;
    logic        err_o;
    logic [39:0] outs_s;

    always #5 clk = ~clk;

    flash_read_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .dout_valid_o(dout_valid_o), .dout_data_o(dout_data_o),
        .dout_id_o(dout_id_o), .dout_last_o(dout_last_o), .dout_ready_i(dout_ready_i),
        .spi_read_o(spi_read_o), .spi_addr_o(spi_addr_o), .spi_ready_i(spi_ready_i),
        .spi_data_i(spi_data_i), .err_o(err_o)
    );

    assign outs_s = {gnt_o, busy_o, dout_valid_o, dout_data_o, dout_id_o, dout_last_o,
                     spi_read_o, spi_addr_o, err_o};

    int checks   = 0;
    int failures = 0;
    int gnt_cnt  = 0;
    int err_cnt  = 0;
    bit gap_en   = 1'b0;
    bit flash_on = 1'b1;

    logic [23:0] addr_q[$];
    logic [9:0]  byte_q[$];   // {data, id, last}

    typedef struct {
        logic [1:0]  req;
        logic [23:0] a0;
        logic [7:0]  l0;
        logic [23:0] a1;
        logic [7:0]  l1;
        logic [1:0]  first;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected spi addresses and delivered bytes for one burst.
    task automatic push_burst(input logic id, input logic [23:0] a, input int nbytes,
                              input int n_addr, input int n_data);
        logic [23:0] x;
        for (int i = 0; i < n_addr; i++) begin
            x = a + 24'(i);
            addr_q.push_back(x);
        end
        for (int i = 0; i < n_data; i++) begin
            x = a + 24'(i);
            byte_q.push_back({flash_byte(x), id, (i == nbytes - 1)});
        end
    endtask

    task automatic wait_gnt(input logic [1:0] exp, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (gnt_o == 2'b00 && n < 2000);
        chk(name, 64'(gnt_o), 64'(exp));
    endtask

    task automatic wait_idle(input string name);
        int n;
        logic [2:0] st;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while ((busy_o || byte_q.size() != 0 || addr_q.size() != 0) && n < 5000);
        st = {busy_o, byte_q.size() == 0, addr_q.size() == 0};
        chk(name, 64'(st), 64'(3'b011));
    endtask

    // Flash reader model: answers each spi_read LAT cycles later.
    initial begin
        logic [23:0] a;
        spi_ready_i = 1'b0;
        spi_data_i  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (spi_read_o && flash_on) begin
                a = spi_addr_o;
                repeat (LAT) @(posedge clk);
                #1;
                spi_ready_i = 1'b1;
                spi_data_i  = flash_byte(a);
                @(posedge clk); #1;
                spi_ready_i = 1'b0;
                spi_data_i  = 8'h00;
            end
        end
    end

    // Output monitor: scoreboard pops on spi_read and on dout accept.
    initial begin
        int  cyc;
        int  rdy_cyc;
        bit  rdy_seen;
        logic [9:0] got;
        cyc = 0; rdy_cyc = 0; rdy_seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (gnt_o != 2'b00) gnt_cnt++;
                if (err_o) err_cnt++;
                if (spi_read_o) begin
                    chk("spi_read_expected", 64'(addr_q.size() != 0), 64'd1);
                    if (addr_q.size() != 0) chk("spi_addr", 64'(spi_addr_o), 64'(addr_q.pop_front()));
                    if (gap_en && rdy_seen) chk("ready_to_read_gap", 64'(cyc - rdy_cyc), 64'd2);
                    rdy_seen = 1'b0;
                end
                if (!busy_o) begin
                    rdy_seen = 1'b0;
                end else if (spi_ready_i) begin
                    rdy_seen = 1'b1;
                    rdy_cyc  = cyc;
                end
                if (dout_valid_o && dout_ready_i) begin
                    chk("dout_expected", 64'(byte_q.size() != 0), 64'd1);
                    if (byte_q.size() != 0) begin
                        got = {dout_data_o, dout_id_o, dout_last_o};
                        chk("dout_data_id_last", 64'(got), 64'(byte_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       t;
        logic [1:0] second;
        logic [7:0] d;
        bit         ok;
        int         n;
        int         reads;

        vecs[0] = '{2'b11, 24'h001000, 8'd0, 24'h002000, 8'd0, 2'b01};
        vecs[1] = '{2'b11, 24'h003000, 8'd0, 24'h004000, 8'd0, 2'b01};
        vecs[2] = '{2'b01, 24'h400000, 8'd3, 24'h000000, 8'd0, 2'b01};
        vecs[3] = '{2'b10, 24'h000000, 8'd0, 24'h123456, 8'd1, 2'b10};
        vecs[4] = '{2'b01, 24'hFFFFFE, 8'd2, 24'h000000, 8'd0, 2'b01};
        vecs[5] = '{2'b11, 24'h000010, 8'd1, 24'h000020, 8'd0, 2'b10};
        vecs[6] = '{2'b10, 24'h000000, 8'd0, 24'hABCDEF, 8'd4, 2'b10};

        rst = 1'b1; req_i = 2'b00; req_addr_i = 48'd0; req_len_i = 16'd0; dout_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(outs_s), 64'd0);
        rst = 1'b0;

        // Table-driven bursts with dout_ready held high.
        gap_en = 1'b1;
        for (int v = 0; v < 7; v++) begin
            t = vecs[v];
            second = t.req & ~t.first;
            if (t.first[0]) push_burst(1'b0, t.a0, int'(t.l0) + 1, int'(t.l0) + 1, int'(t.l0) + 1);
            else            push_burst(1'b1, t.a1, int'(t.l1) + 1, int'(t.l1) + 1, int'(t.l1) + 1);
            if (second[0])      push_burst(1'b0, t.a0, int'(t.l0) + 1, int'(t.l0) + 1, int'(t.l0) + 1);
            else if (second[1]) push_burst(1'b1, t.a1, int'(t.l1) + 1, int'(t.l1) + 1, int'(t.l1) + 1);
            gnt_cnt    = 0;
            req_addr_i = {t.a1, t.a0};
            req_len_i  = {t.l1, t.l0};
            req_i      = t.req;
            wait_gnt(t.first, $sformatf("v%0d_gnt_first", v));
            req_i = req_i & ~t.first;
            if (second != 2'b00) begin
                wait_gnt(second, $sformatf("v%0d_gnt_second", v));
                req_i = req_i & ~second;
            end
            wait_idle($sformatf("v%0d_drain", v));
            chk($sformatf("v%0d_gnt_count", v), 64'(gnt_cnt), (second != 2'b00) ? 64'd2 : 64'd1);
        end

        // Consumer stall on byte 2 of a 3-byte burst.
        gap_en = 1'b0;
        push_burst(1'b1, 24'h000300, 3, 3, 3);
        req_addr_i = {24'h000300, 24'h000000};
        req_len_i  = {8'd2, 8'd0};
        req_i      = 2'b10;
        wait_gnt(2'b10, "stall_gnt");
        req_i = 2'b00;
        n = 0;
        while (!dout_valid_o && n < 500) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        dout_ready_i = 1'b0;
        n = 0;
        while (!dout_valid_o && n < 500) begin @(posedge clk); #1; n++; end
        d  = dout_data_o;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dout_data_o !== d || dout_valid_o !== 1'b1 || spi_read_o !== 1'b0) ok = 1'b0;
        end
        chk("stall_hold_stable", 64'(ok), 64'd1);
        chk("stall_byte2_value", 64'(d), 64'(flash_byte(24'h000301)));
        dout_ready_i = 1'b1;
        wait_idle("stall_drain");

        // Flash never answers: timeout, then a late completion is ignored.
        flash_on = 1'b0;
        err_cnt  = 0;
        addr_q.push_back(24'h0000AA);
        req_addr_i = {24'h000000, 24'h0000AA};
        req_len_i  = 16'd0;
        req_i      = 2'b01;
        wait_gnt(2'b01, "timeout_gnt");
        req_i = 2'b00;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!err_o && n < 400);
        chk("timeout_cycles_from_issue", 64'(n), 64'(TO + 1));
        chk("timeout_back_to_idle", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk("err_single_pulse", 64'(err_o), 64'd0);
        spi_ready_i = 1'b1;
        spi_data_i  = 8'h77;
        @(posedge clk); #1;
        spi_ready_i = 1'b0;
        spi_data_i  = 8'h00;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (dout_valid_o || busy_o) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("late_ready_ignored", 64'(ok), 64'd1);
        chk("err_count", 64'(err_cnt), 64'd1);
        flash_on = 1'b1;

        // Reset while waiting on byte 3 of a 5-byte burst.
        push_burst(1'b0, 24'h000500, 5, 3, 2);
        req_addr_i = {24'h000000, 24'h000500};
        req_len_i  = {8'd0, 8'd4};
        req_i      = 2'b01;
        wait_gnt(2'b01, "midrst_gnt");
        req_i = 2'b00;
        reads = 1;
        n = 0;
        while (reads < 3 && n < 1000) begin
            @(posedge clk); #1; n++;
            if (spi_read_o) reads++;
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outputs", 64'(outs_s), 64'd0);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (dout_valid_o || busy_o) ok = 1'b0;
        end
        chk("midrst_quiet_after", 64'(ok), 64'd1);
        chk("midrst_queues_empty", 64'(addr_q.size() + byte_q.size()), 64'd0);
        push_burst(1'b1, 24'h000600, 1, 1, 1);
        req_addr_i = {24'h000600, 24'h000000};
        req_len_i  = 16'd0;
        req_i      = 2'b10;
        wait_gnt(2'b10, "postrst_gnt");
        req_i = 2'b00;
        wait_idle("postrst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of cycles WAIT tolerates without spi_ready.
REQ-002 clk  input  1  rising-edge clock for all logic.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester burst request level, held until the matching gnt bit.
REQ-005 req_addr  input  48  start addresses: [23:0] requester 0, [47:24] requester 1.
REQ-006 req_len  input  16  burst lengths minus one: [7:0] requester 0, [15:8] requester 1; bursts are 1..256 bytes.
REQ-007 gnt  output  2  one-cycle pulse when a request is latched.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 dout_valid / dout_data / dout_id / dout_last  output  1/8/1/1  byte stream: data, owning requester, final byte of burst.
REQ-010 dout_ready  input  1  consumer accepts a byte when dout_valid and dout_ready are both high.
REQ-011 spi_read / spi_addr  output  1/24  byte-read command to the flash reader.
REQ-012 spi_ready / spi_data  input  1/8  flash reader completion pulse and byte.
REQ-013 err  output  1  one-cycle pulse when a burst is aborted on timeout.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DELIVER.
REQ-015 IDLE with any req bit high: pick the winner, latch its addr/len, pulse gnt for one cycle, go to ISSUE.
REQ-016 Arbitration is round-robin: when both req bits are high, the requester not served last wins; after reset requester 0 wins.
REQ-017 ISSUE: spi_read high for exactly one cycle with spi_addr = current address, then go to WAIT.
REQ-018 spi_addr holds its value from ISSUE through the end of WAIT.
REQ-019 WAIT on spi_ready: register spi_data into dout_data, set dout_valid, go to DELIVER.
REQ-020 dout_last is set when the remaining count is 0.
REQ-021 DELIVER holds dout_valid, dout_data, dout_id and dout_last stable until dout_ready.
REQ-022 DELIVER on accept with remaining = 0: clear dout_valid, record the last-served requester, go to IDLE.
REQ-023 DELIVER on accept with remaining > 0: clear dout_valid, increment address mod 2^24 (0xFFFFFF wraps to 0x000000), decrement remaining, go to ISSUE.
REQ-024 WAIT counts cycles; when the count reaches TIMEOUT without spi_ready, pulse err, drop the burst, mark that requester as last served, go to IDLE.
REQ-025 spi_ready outside WAIT is ignored, including a late completion after a timeout or after reset.
REQ-026 A req bit dropped before its gnt latches nothing.
REQ-027 req changes during a burst do not affect the burst in progress.
REQ-028 Minimum per-byte overhead beyond flash latency: 1 ISSUE cycle + 1 DELIVER cycle.
REQ-029 With dout_ready tied high, the next spi_read follows the previous spi_ready by 2 cycles.

Reset
REQ-030 rst forces IDLE at any point, including mid-burst.
REQ-031 rst clears gnt, busy, dout_valid, dout_last, dout_id, spi_read, err, the timeout counter and remaining count.
REQ-032 rst sets dout_data = 0x00, spi_addr = 0x000000, and last-served = requester 1, so requester 0 has priority.
REQ-033 The flash reader has no reset; a spi_ready arriving after rst falls under REQ-025.

Structure
REQ-034 Shared package flash_arb_pkg holds the state encoding, the ADDR_W=24 and LEN_W=8 constants, and the default TIMEOUT.
REQ-035 The 2-way round-robin picker is a sub-module flash_arb_rr (inputs: req, last-served; output: one-hot winner).

Verification
REQ-036 req=01, addr0=0x400000, len0=3, flash model latency 48, dout_ready=1 -> spi_addr 0x400000..0x400003, 4 bytes, dout_id=0, dout_last only on the 4th byte, gnt=01 once.
REQ-037 req=11 in the same cycle, both len=0 -> requester 0 served first, then requester 1; repeating both -> order 0,1,0,1.
REQ-038 addr0=0xFFFFFE, len0=2 -> spi_addr sequence 0xFFFFFE, 0xFFFFFF, 0x000000.
REQ-039 dout_ready low for 20 cycles on byte 2 -> dout_data stable throughout, no spi_read issued until accept.
REQ-040 flash model never answers -> err pulse 255 cycles after entering WAIT, return to IDLE; a late spi_ready then produces no dout_valid.
REQ-041 rst asserted in WAIT of byte 3 of 5 -> next cycle all outputs at reset values; a following req=10 is granted normally.
